mdu_scheduler: RTL and testbench

- Multi-cycle multiply/divide controller in the EXE stage, alongside the single-cycle ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EXE and sequences an iterative radix-2 divider and a registered multiplier.
- Owns the architectural HI/LO registers.
- Raises a stall request so the instruction is held in EXE until its result commits.

---
 rtl/mdu_scheduler_if.sv | 24 ++
 rtl/mdu_scheduler.sv | 176 +++++++++++++++++
 tb/tb_mdu_scheduler.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdu_scheduler_if.sv
// EXE-stage <-> multiply/divide unit bundle.
// The EXE side (master) presents the instruction and operands.
// The MDU side (slave) returns the stall request and the architectural HI/LO.
interface mdu_scheduler_if;
  logic        EXE_MDUValid;
  logic [2:0]  EXE_MDUOp;
  logic [31:0] EXE_ResultA;
  logic [31:0] EXE_ResultB;
  logic        EXE_Stall;
  logic        EXE_Flush;
  logic        EXE_MDUBusy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output EXE_MDUValid, EXE_MDUOp, EXE_ResultA, EXE_ResultB, EXE_Stall, EXE_Flush,
    input  EXE_MDUBusy, HI, LO
  );

  modport slave (
    input  EXE_MDUValid, EXE_MDUOp, EXE_ResultA, EXE_ResultB, EXE_Stall, EXE_Flush,
    output EXE_MDUBusy, HI, LO
  );
endinterface

// File: rtl/mdu_scheduler.sv
// Multi-cycle multiply/divide controller for the EXE stage.
// It sequences a registered multiplier and a radix-2 restoring divider, owns
// HI/LO, and holds the issuing instruction in EXE through EXE_MDUBusy.
// A DONE state keeps the finished instruction, which is still in EXE, from
// being accepted a second time.
module mdu_scheduler #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 32
) (
  input logic          clk,
  input logic          rst,
  mdu_scheduler_if.slave mdu
);

  localparam int CW = $clog2((DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES) + 1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_a;
  logic [31:0]   r_b;
  logic          r_signed;
  logic          r_sa;
  logic          r_sb;
  logic [31:0]   r_rem;
  logic [31:0]   r_quo;   // dividend bits shift out as quotient bits shift in
  logic [31:0]   r_dvs;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;

  logic          w_op_arith;
  logic          w_op_div;
  logic          w_op_signed;
  logic          w_accept;
  logic          w_mt_write;
  logic          w_commit;
  logic [31:0]   w_mag_a;
  logic [31:0]   w_mag_b;
  logic [63:0]   w_ext_a;
  logic [63:0]   w_ext_b;
  logic [63:0]   w_prod;
  logic [32:0]   w_shift;
  logic [33:0]   w_trial;
  logic          w_fits;
  logic [31:0]   w_rem_next;
  logic [31:0]   w_quo_next;
  logic [31:0]   w_quo_final;
  logic [31:0]   w_rem_final;

  // Decode the EXE instruction; reset is folded in so nothing looks accepted
  // (and Busy stays low) while the unit is held in reset.
  always_comb begin
    w_op_arith  = (mdu.EXE_MDUOp == OP_MULT) || (mdu.EXE_MDUOp == OP_MULTU) ||
                  (mdu.EXE_MDUOp == OP_DIV)  || (mdu.EXE_MDUOp == OP_DIVU);
    w_op_div    = (mdu.EXE_MDUOp == OP_DIV)  || (mdu.EXE_MDUOp == OP_DIVU);
    w_op_signed = (mdu.EXE_MDUOp == OP_MULT) || (mdu.EXE_MDUOp == OP_DIV);
    w_accept    = (r_state == S_IDLE) && mdu.EXE_MDUValid && !mdu.EXE_Flush &&
                  w_op_arith && !rst;
    w_mt_write  = (r_state == S_IDLE) && mdu.EXE_MDUValid && !mdu.EXE_Flush &&
                  ((mdu.EXE_MDUOp == OP_MTHI) || (mdu.EXE_MDUOp == OP_MTLO));
    // Magnitudes for signed division; 0x8000_0000 negates to itself = 2^31.
    w_mag_a     = (w_op_signed && mdu.EXE_ResultA[31]) ? (~mdu.EXE_ResultA + 32'd1)
                                                       : mdu.EXE_ResultA;
    w_mag_b     = (w_op_signed && mdu.EXE_ResultB[31]) ? (~mdu.EXE_ResultB + 32'd1)
                                                       : mdu.EXE_ResultB;
  end

  // Multiplier: sign- or zero-extend the latched operands; the low 64 bits of
  // the 64x64 product are the correct product for both MULT and MULTU.
  always_comb begin
    w_ext_a = r_signed ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
    w_ext_b = r_signed ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
    w_prod  = w_ext_a * w_ext_b;
  end

  // One restoring-division step. A zero divisor always "fits", which yields
  // an all-ones quotient and leaves the dividend magnitude as remainder.
  always_comb begin
    w_shift     = {r_rem, r_quo[31]};
    w_trial     = {1'b0, w_shift} - {2'b00, r_dvs};
    w_fits      = !w_trial[33];
    w_rem_next  = w_fits ? w_trial[31:0] : w_shift[31:0];
    w_quo_next  = {r_quo[30:0], w_fits};
    w_quo_final = (r_signed && (r_sa ^ r_sb)) ? (~w_quo_next + 32'd1) : w_quo_next;
    w_rem_final = (r_signed && r_sa) ? (~w_rem_next + 32'd1) : w_rem_next;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state, commit strobe and stall request; a flush overrides everything.
  always_comb begin
    w_state_next    = r_state;
    w_commit        = 1'b0;
    mdu.EXE_MDUBusy = w_accept || (r_state == S_MUL) || (r_state == S_DIV);
    case (r_state)
      S_IDLE: if (w_accept) w_state_next = w_op_div ? S_DIV : S_MUL;
      S_MUL, S_DIV: begin
        if (r_cnt == '0) begin
          w_state_next = S_DONE;
          w_commit     = 1'b1;
        end
      end
      S_DONE: if (!mdu.EXE_Stall) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (mdu.EXE_Flush) begin
      w_state_next = S_IDLE;
      w_commit     = 1'b0;
    end
  end

  // Operand latch, iteration counter and divider working registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
    end else if (w_accept) begin
      r_cnt    <= w_op_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
      r_a      <= mdu.EXE_ResultA;
      r_b      <= mdu.EXE_ResultB;
      r_signed <= w_op_signed;
      r_sa     <= w_op_signed && mdu.EXE_ResultA[31];
      r_sb     <= w_op_signed && mdu.EXE_ResultB[31];
      r_rem    <= '0;
      r_quo    <= w_mag_a;
      r_dvs    <= w_mag_b;
    end else if ((r_state == S_MUL) || (r_state == S_DIV)) begin
      if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
      if (r_state == S_DIV) begin
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
      end
    end
  end

  // Architectural HI/LO: written only by a commit or by MTHI/MTLO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_commit && (r_state == S_MUL)) begin
      r_hi <= w_prod[63:32];
      r_lo <= w_prod[31:0];
    end else if (w_commit && (r_state == S_DIV)) begin
      r_hi <= w_rem_final;
      r_lo <= w_quo_final;
    end else if (w_mt_write) begin
      if (mdu.EXE_MDUOp == OP_MTHI) r_hi <= mdu.EXE_ResultA;
      else                          r_lo <= mdu.EXE_ResultA;
    end
  end

  assign mdu.HI = r_hi;
  assign mdu.LO = r_lo;

endmodule

// File: tb/tb_mdu_scheduler.sv
// Self-checking bench for mdu_scheduler: directed cases plus random traffic.
// A driver issues instructions and pushes expected HI/LO/busy-length records;
// a monitor measures each busy run and checks it against the scoreboard.
module tb_mdu_scheduler;
  localparam int MULC = 2;
  localparam int DIVC = 32;

  logic clk;
  logic rst;
  mdu_scheduler_if u_if ();

  mdu_scheduler #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (u_if)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          n_txn    = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference results {HI, LO} straight from the arithmetic definitions.
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0]     q64, r64;
    ref_model = 64'd0;
    case (op)
      3'd1: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ref_model = 64'(sa * sb);
      end
      3'd2: begin
        ua = 64'(a);
        ub = 64'(b);
        ref_model = ua * ub;
      end
      3'd3: begin
        if (b == 32'd0) begin
          ref_model = {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
        end else begin
          sa  = longint'($signed(a));
          sb  = longint'($signed(b));
          sq  = sa / sb;
          sr  = sa % sb;
          q64 = 64'(sq);
          r64 = 64'(sr);
          ref_model = {r64[31:0], q64[31:0]};
        end
      end
      3'd4: begin
        if (b == 32'd0) ref_model = {a, 32'hFFFF_FFFF};
        else            ref_model = {a % b, a / b};
      end
      default: ref_model = {m_hi, m_lo};
    endcase
  endfunction

  // Monitor: a completed busy run is one transaction's response.
  initial begin
    int   run;
    exp_t e;
    run = 0;
    forever begin
      @(negedge clk);
      if (u_if.EXE_MDUBusy === 1'b1) begin
        run++;
      end else if (run > 0) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_unexpected: got busy run %0d expected none", run);
        end else begin
          e = sb_q.pop_front();
          check("busy_len", 32'(run), 32'(e.len));
          check("hi", u_if.HI, e.hi);
          check("lo", u_if.LO, e.lo);
        end
        run = 0;
      end
    end
  end

  // Issue MULT/MULTU/DIV/DIVU. flush_at: 0 none, 1 on the accept cycle
  // (blocks the accept), N>1 on busy cycle N. stall_n: EXE_Stall is held
  // through the busy period and for stall_n cycles after completion.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input int stall_n);
    logic [63:0] r;
    exp_t        e;
    int          full;
    int          c;
    logic        bz;
    r    = ref_model(op, a, b);
    full = (op <= 3'd2) ? 1 + MULC : 1 + DIVC;
    n_txn++;
    $display("txn %0d: op=%0d a=%h b=%h flush_at=%0d stall=%0d", n_txn, op, a, b, flush_at, stall_n);
    if (flush_at != 1) begin
      e.hi  = (flush_at == 0) ? r[63:32] : m_hi;
      e.lo  = (flush_at == 0) ? r[31:0]  : m_lo;
      e.len = (flush_at == 0) ? full : flush_at;
      sb_q.push_back(e);
      if (flush_at == 0) begin
        m_hi = r[63:32];
        m_lo = r[31:0];
      end
    end
    @(posedge clk); #1;
    u_if.EXE_MDUValid = 1'b1;
    u_if.EXE_MDUOp    = op;
    u_if.EXE_ResultA  = a;
    u_if.EXE_ResultB  = b;
    u_if.EXE_Stall    = (stall_n > 0);
    u_if.EXE_Flush    = 1'b0;
    c = 1;
    forever begin
      if (c == flush_at) u_if.EXE_Flush = 1'b1;
      @(negedge clk);
      bz = u_if.EXE_MDUBusy;
      if (flush_at == 1) check("flush_blocks_accept", 32'(bz), 32'd0);
      @(posedge clk); #1;
      if (u_if.EXE_Flush) begin
        u_if.EXE_Flush    = 1'b0;
        u_if.EXE_MDUValid = 1'b0;
        u_if.EXE_Stall    = 1'b0;
        u_if.EXE_MDUOp    = 3'd0;
        @(negedge clk);
        check("flush_busy", 32'(u_if.EXE_MDUBusy), 32'd0);
        check("flush_hi", u_if.HI, m_hi);
        check("flush_lo", u_if.LO, m_lo);
        return;
      end
      if (!bz) break;
      c++;
      if (c > 200) begin
        n_checks++;
        n_err++;
        $display("FAIL timeout: got busy after %0d cycles expected %0d", c, full);
        u_if.EXE_MDUValid = 1'b0;
        u_if.EXE_Stall    = 1'b0;
        return;
      end
    end
    if (stall_n > 0) begin
      repeat (stall_n - 1) begin
        @(negedge clk);
        check("stall_busy", 32'(u_if.EXE_MDUBusy), 32'd0);
        @(posedge clk); #1;
      end
      u_if.EXE_Stall = 1'b0;
      @(negedge clk);
      check("unstall_busy", 32'(u_if.EXE_MDUBusy), 32'd0);
      @(posedge clk); #1;
    end
    u_if.EXE_MDUValid = 1'b0;
    u_if.EXE_MDUOp    = 3'd0;
    @(negedge clk);
    check("hold_hi", u_if.HI, m_hi);
    check("hold_lo", u_if.LO, m_lo);
  endtask

  // Issue MTHI/MTLO, optionally flushed, held stall_n extra cycles.
  task automatic run_mt(input logic [2:0] op, input logic [31:0] a, input logic fl,
                        input int stall_n);
    n_txn++;
    $display("txn %0d: op=%0d a=%h flush=%0d stall=%0d", n_txn, op, a, fl, stall_n);
    @(posedge clk); #1;
    u_if.EXE_MDUValid = 1'b1;
    u_if.EXE_MDUOp    = op;
    u_if.EXE_ResultA  = a;
    u_if.EXE_Flush    = fl;
    u_if.EXE_Stall    = (stall_n > 0);
    repeat (1 + stall_n) begin
      @(negedge clk);
      check("mt_busy", 32'(u_if.EXE_MDUBusy), 32'd0);
      @(posedge clk); #1;
    end
    u_if.EXE_MDUValid = 1'b0;
    u_if.EXE_MDUOp    = 3'd0;
    u_if.EXE_Flush    = 1'b0;
    u_if.EXE_Stall    = 1'b0;
    if (!fl) begin
      if (op == 3'd5) m_hi = a;
      else            m_lo = a;
    end
    @(negedge clk);
    check("mt_hi", u_if.HI, m_hi);
    check("mt_lo", u_if.LO, m_lo);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       pick_operand = 32'd0;
      1:       pick_operand = 32'h8000_0000;
      2:       pick_operand = 32'hFFFF_FFFF;
      3:       pick_operand = 32'($urandom_range(0, 20));
      default: pick_operand = $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0] op;
    int         full;
    int         fa;
    rst               = 1'b1;
    u_if.EXE_MDUValid = 1'b0;
    u_if.EXE_MDUOp    = 3'd0;
    u_if.EXE_ResultA  = 32'd0;
    u_if.EXE_ResultB  = 32'd0;
    u_if.EXE_Stall    = 1'b0;
    u_if.EXE_Flush    = 1'b0;
    #3;
    check("reset_busy", 32'(u_if.EXE_MDUBusy), 32'd0);
    check("reset_hi", u_if.HI, 32'd0);
    check("reset_lo", u_if.LO, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases
    run_op(3'd1, 32'hFFFF_FFFB, 32'd3, 0, 0);
    run_op(3'd4, 32'd100, 32'd7, 0, 0);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(3'd4, 32'd9, 32'd0, 0, 0);
    run_op(3'd3, 32'hFFFF_FFF7, 32'd0, 0, 0);
    run_mt(3'd5, 32'h1234_5678, 1'b0, 0);
    run_mt(3'd6, 32'h1234_5678, 1'b0, 2);
    run_op(3'd4, 32'd1000, 32'd3, 10, 0);
    run_op(3'd2, 32'd2, 32'd3, 0, 4);
    run_op(3'd3, 32'd50, 32'd5, 1, 0);
    run_mt(3'd5, 32'hDEAD_BEEF, 1'b1, 0);
    run_op(3'd3, 32'd77, 32'd5, 1 + DIVC, 0);
    run_op(3'd1, 32'd6, 32'd7, 1 + MULC, 0);

    // Asynchronous reset in the middle of a division
    n_txn++;
    $display("txn %0d: op=3 reset on busy cycle 5", n_txn);
    sb_q.push_back('{hi: 32'd0, lo: 32'd0, len: 4});
    @(posedge clk); #1;
    u_if.EXE_MDUValid = 1'b1;
    u_if.EXE_MDUOp    = 3'd3;
    u_if.EXE_ResultA  = 32'd12345;
    u_if.EXE_ResultB  = 32'd11;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy", 32'(u_if.EXE_MDUBusy), 32'd0);
    check("rst_hi", u_if.HI, 32'd0);
    check("rst_lo", u_if.LO, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    u_if.EXE_MDUValid = 1'b0;
    u_if.EXE_MDUOp    = 3'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_op(3'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 0, 0);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(1, 6));
      if (op >= 3'd5) begin
        run_mt(op, pick_operand(), ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
      end else begin
        full = (op <= 3'd2) ? 1 + MULC : 1 + DIVC;
        fa   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, full) : 0;
        run_op(op, pick_operand(), pick_operand(), fa, $urandom_range(0, 3));
      end
    end

    repeat (5) @(posedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
